// File: rtl/keypad_scan.sv
// 4x4 matrix-keypad scanner with frame-based debounce; keys[col*4+row] is active-high.
// Optional macro KEYSCAN_SYNC_EN inserts a 2-flop synchroniser on row_in before sampling.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DB_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        key_event,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = $clog2(DB_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AGREE_MAX = AW'(DB_SCANS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   frame_q, frame_d;
  logic [15:0]   cand_q, cand_d;
  logic [AW-1:0] agree_q, agree_d;
  logic [15:0]   keys_q, keys_d;
  logic          key_event_q, key_event_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    row_sample;

`ifdef KEYSCAN_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  assign row_sample = ~sync2_q;
`else
  assign row_sample = ~row_in;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      col_q        <= 2'd0;
      frame_q      <= 16'h0000;
      cand_q       <= 16'h0000;
      agree_q      <= '0;
      keys_q       <= 16'h0000;
      key_event_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      cand_q       <= cand_d;
      agree_q      <= agree_d;
      keys_q       <= keys_d;
      key_event_q  <= key_event_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Debounce is evaluated against the frame completed on this edge, so keys
  // updates in the same cycle frame_done is seen high.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    col_d        = col_q;
    frame_d      = frame_q;
    cand_d       = cand_q;
    agree_d      = agree_q;
    keys_d       = keys_q;
    key_event_d  = 1'b0;
    frame_done_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      col_d = col_q + 2'd1;
      frame_d[{col_q, 2'b00} +: 4] = row_sample;
      if (col_q == 2'd3) begin
        frame_done_d = 1'b1;
        if (frame_d != cand_q) begin
          cand_d  = frame_d;
          agree_d = AW'(1);
        end else if (agree_q != AGREE_MAX) begin
          agree_d = agree_q + 1'b1;
        end
        if ((agree_d == AGREE_MAX) && (cand_d != keys_q)) begin
          keys_d      = cand_d;
          key_event_d = 1'b1;
        end
      end
    end
  end

  assign col_out    = ~(4'b0001 << col_q);
  assign keys       = keys_q;
  assign key_event  = key_event_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised and directed bench for keypad_scan against a cycle-counting reference model.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DB_SCANS = 2;
`ifdef KEYSCAN_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        key_event;
  logic        frame_done;

  logic [15:0] pressed;
  logic        check_enable;
  int          check_count;
  int          error_count;
  int          event_count;
  int          done_count;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DB_SCANS(DB_SCANS)) dut (
    .clock(clock),
    .reset(reset),
    .row_in(row_in),
    .col_out(col_out),
    .keys(keys),
    .key_event(key_event),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its row to whichever column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (!col_out[c]) row_in = row_in & ~pressed[c*4 +: 4];
  end

  // Reference model: cycle index since reset decides column and sample edges.
  int          m_cycle;
  int          m_agree;
  logic [15:0] m_frame, m_cand, m_keys;
  logic        m_event, m_done;
  logic [3:0]  m_h1, m_h2;
  logic [3:0]  m_smp;
  logic [15:0] m_f, m_nc;
  int          m_na, m_col;
  logic [3:0]  exp_col;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cycle <= 0;
      m_agree <= 0;
      m_frame <= 16'h0;
      m_cand  <= 16'h0;
      m_keys  <= 16'h0;
      m_event <= 1'b0;
      m_done  <= 1'b0;
      m_h1    <= 4'hF;
      m_h2    <= 4'hF;
    end else begin
      m_col = (m_cycle / SCAN_DIV) % 4;
      m_smp = SYNC ? ~m_h2 : ~row_in;
      m_f = m_frame;
      m_f[m_col*4 +: 4] = m_smp;
      m_event <= 1'b0;
      m_done  <= 1'b0;
      if ((m_cycle % SCAN_DIV) == SCAN_DIV - 1) begin
        m_frame <= m_f;
        if (m_col == 3) begin
          m_done <= 1'b1;
          if (m_f != m_cand) begin
            m_nc = m_f;
            m_na = 1;
          end else begin
            m_nc = m_cand;
            m_na = (m_agree + 1 > DB_SCANS) ? DB_SCANS : m_agree + 1;
          end
          m_cand  <= m_nc;
          m_agree <= m_na;
          if (m_na == DB_SCANS && m_nc != m_keys) begin
            m_keys  <= m_nc;
            m_event <= 1'b1;
          end
        end
      end
      m_cycle <= m_cycle + 1;
      m_h2 <= m_h1;
      m_h1 <= row_in;
    end
  end

  always_comb exp_col = ~(4'b0001 << ((m_cycle / SCAN_DIV) % 4));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] pattern, input int cycles);
    pressed = pattern;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic waitKeys(input string tag, input logic [15:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (keys == exp) break;
    end
    checkOutput(tag, 32'(keys), 32'(exp));
  endtask

  always @(negedge clock) begin
    if (key_event) event_count++;
    if (frame_done) done_count++;
    if (check_enable) begin
      checkOutput("col_out", 32'(col_out), 32'(exp_col));
      checkOutput("col_onecold", 32'($countones(~col_out)), 32'd1);
      checkOutput("keys", 32'(keys), 32'(m_keys));
      checkOutput("key_event", 32'(key_event), 32'(m_event));
      checkOutput("frame_done", 32'(frame_done), 32'(m_done));
    end
  end

  int ev_base, done_base;
  logic [15:0] pat;

  initial begin
    check_count  = 0;
    error_count  = 0;
    event_count  = 0;
    done_count   = 0;
    check_enable = 1'b0;
    pressed      = 16'h0;
    reset        = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_keys", 32'(keys), 32'h0);
    checkOutput("rst_col", 32'(col_out), 32'hE);
    checkOutput("rst_event", 32'(key_event), 32'h0);
    checkOutput("rst_done", 32'(frame_done), 32'h0);
    #2 reset = 1'b0;
    check_enable = 1'b1;

    // Idle scanning: one frame_done per 16 cycles, no events.
    @(negedge clock); #1;
    ev_base = event_count; done_base = done_count;
    repeat (160) @(negedge clock); #1;
    checkOutput("idle_frames", 32'(done_count - done_base), 32'd10);
    checkOutput("idle_events", 32'(event_count - ev_base), 32'd0);
    checkOutput("idle_keys", 32'(keys), 32'h0);

    // Key 5 press, hold, release.
    ev_base = event_count;
    pressed = 16'h0020;
    waitKeys("key5_press", 16'h0020, 51);
    applyStimulus(16'h0020, 100); #1;
    checkOutput("key5_one_event", 32'(event_count - ev_base), 32'd1);
    pressed = 16'h0000;
    waitKeys("key5_release", 16'h0000, 51);
    applyStimulus(16'h0000, 40); #1;
    checkOutput("key5_two_events", 32'(event_count - ev_base), 32'd2);

    // Keys 0 and 15 together.
    ev_base = event_count;
    pressed = 16'h8001;
    waitKeys("keys_0_15", 16'h8001, 51);
    applyStimulus(16'h8001, 60); #1;
    checkOutput("keys_0_15_event", 32'(event_count - ev_base), 32'd1);
    applyStimulus(16'h0000, 60);
    checkOutput("keys_0_15_release", 32'(keys), 32'h0);

    // Key 10 bounces one frame on, one frame off, then holds.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0400, 16);
      checkOutput("bounce_quiet_on", 32'(keys), 32'h0);
      applyStimulus(16'h0000, 16);
      checkOutput("bounce_quiet_off", 32'(keys), 32'h0);
    end
    applyStimulus(16'h0400, 16);
    checkOutput("bounce_one_frame", 32'(keys), 32'h0);
    waitKeys("bounce_settle", 16'h0400, 40);
    applyStimulus(16'h0000, 60);

    // Reset mid-dwell of column 2 while key 3 is held.
    pressed = 16'h0008;
    waitKeys("key3_press", 16'h0008, 51);
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (col_out == 4'b1011) break;
    end
    checkOutput("reach_col2", 32'(col_out), 32'hB);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_keys", 32'(keys), 32'h0);
    checkOutput("midrst_col", 32'(col_out), 32'hE);
    checkOutput("midrst_event", 32'(key_event), 32'h0);
    @(posedge clock);
    #2 reset = 1'b0;
    waitKeys("key3_after_reset", 16'h0008, 60);
    applyStimulus(16'h0000, 60);

    // Random patterns with optional bounce bursts; model tracks every cycle.
    for (int it = 0; it < 16; it++) begin
      pat = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0; b < 6; b++)
          applyStimulus(16'($urandom) & pat, $urandom_range(1, 10));
      end
      applyStimulus(pat, $urandom_range(55, 90));
      checkOutput("rand_settle", 32'(keys), 32'(pat));
    end

    check_enable = 1'b0;
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
